// File: rtl/rtc_bcd_clock.sv
// ============================================================================
// Module      : rtc_bcd_clock
// Description : Free-running BCD calendar clock. Loads host time, advances one
//               second every CLK_HZ cycles and carries through min/hour/date/
//               month/year/day-of-week with month lengths and leap years.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bcd_clock #(
  parameter int CLK_HZ = 32000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rtc_in,
  input  logic        rtc_load,
  output logic [63:0] rtc_out,
  output logic        sec_tick,
  output logic        rtc_valid
);

  localparam int              PCNT_W   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(CLK_HZ - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);
  localparam logic [63:0]     RTC_RESET = 64'h0001_0001_0100_0000;

  // Prescaler and terminal-count strobe
  logic [PCNT_W-1:0] pcnt;
  logic              adv;

  // Current field views of the running time
  logic [7:0] cur_sec, cur_min, cur_hour, cur_date;
  logic [7:0] cur_mon, cur_year, cur_dow, cur_spare;

  // Carry-chain results
  logic [7:0] nxt_sec, nxt_min, nxt_hour, nxt_date;
  logic [7:0] nxt_mon, nxt_year, nxt_dow;
  logic       sec_wrap, min_wrap, hour_wrap, date_wrap, mon_wrap;
  logic       min_en, hour_en, date_en, mon_en, year_en;
  logic       leap;
  logic [7:0] mlen;
  logic [63:0] rtc_next;

  // BCD increment: units 9 rolls to 0 and bumps the tens digit. Out-of-range
  // digits simply count up; the caller's >= compare catches them later.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'h9) begin
      r = {v[7:4] + 4'h1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

  // Binary year mod 4 == 0 expressed on BCD digits: 10 is 2 mod 4, so an even
  // tens digit needs units in {0,4,8} and an odd tens digit needs {2,6}.
  function automatic logic is_leap(input logic [7:0] yr);
    logic r;
    if (!yr[4]) begin
      r = (yr[3:0] == 4'h0) || (yr[3:0] == 4'h4) || (yr[3:0] == 4'h8);
    end else begin
      r = (yr[3:0] == 4'h2) || (yr[3:0] == 4'h6);
    end
    return r;
  endfunction

  // Last date of the month in BCD; unknown month codes behave as 31-day months.
  function automatic logic [7:0] month_len(input logic [7:0] mon, input logic lp);
    logic [7:0] r;
    case (mon)
      8'h01, 8'h03, 8'h05, 8'h07,
      8'h08, 8'h10, 8'h12:         r = 8'h31;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      8'h02:                       r = lp ? 8'h29 : 8'h28;
      default:                     r = 8'h31;
    endcase
    return r;
  endfunction

  assign cur_sec   = rtc_out[7:0];
  assign cur_min   = rtc_out[15:8];
  assign cur_hour  = rtc_out[23:16];
  assign cur_date  = rtc_out[31:24];
  assign cur_mon   = rtc_out[39:32];
  assign cur_year  = rtc_out[47:40];
  assign cur_dow   = rtc_out[55:48];
  assign cur_spare = rtc_out[63:56];

  assign adv = (pcnt == PCNT_MAX);

  // Full one-step carry chain from seconds up to year and day-of-week
  always_comb begin
    leap      = is_leap(cur_year);
    mlen      = month_len(cur_mon, leap);

    sec_wrap  = (cur_sec  >= 8'h59);
    min_wrap  = (cur_min  >= 8'h59);
    hour_wrap = (cur_hour >= 8'h23);
    date_wrap = (cur_date >= mlen);
    mon_wrap  = (cur_mon  >= 8'h12);

    min_en    = sec_wrap;
    hour_en   = min_en  & min_wrap;
    date_en   = hour_en & hour_wrap;
    mon_en    = date_en & date_wrap;
    year_en   = mon_en  & mon_wrap;

    nxt_sec   = sec_wrap ? 8'h00 : bcd_inc(cur_sec);

    nxt_min   = cur_min;
    if (min_en) begin
      nxt_min = min_wrap ? 8'h00 : bcd_inc(cur_min);
    end

    nxt_hour  = cur_hour;
    if (hour_en) begin
      nxt_hour = hour_wrap ? 8'h00 : bcd_inc(cur_hour);
    end

    nxt_date  = cur_date;
    if (date_en) begin
      nxt_date = date_wrap ? 8'h01 : bcd_inc(cur_date);
    end

    nxt_mon   = cur_mon;
    if (mon_en) begin
      nxt_mon = mon_wrap ? 8'h01 : bcd_inc(cur_mon);
    end

    nxt_year  = cur_year;
    if (year_en) begin
      nxt_year = (cur_year >= 8'h99) ? 8'h00 : bcd_inc(cur_year);
    end

    // Day-of-week moves once per midnight, i.e. whenever the date is bumped.
    // It is a 1..7 counter, never more than one digit, so a plain +1 suffices.
    nxt_dow   = cur_dow;
    if (date_en) begin
      nxt_dow = (cur_dow >= 8'h07) ? 8'h01 : (cur_dow + 8'h01);
    end

    rtc_next  = {cur_spare, nxt_dow, nxt_year, nxt_mon,
                 nxt_date, nxt_hour, nxt_min, nxt_sec};
  end

  // Prescaler, time register and status flags; reset beats load beats tick
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt      <= '0;
      rtc_out   <= RTC_RESET;
      sec_tick  <= 1'b0;
      rtc_valid <= 1'b0;
    end else if (rtc_load) begin
      // A load in the terminal-count cycle swallows that tick entirely.
      pcnt      <= '0;
      rtc_out   <= rtc_in;
      sec_tick  <= 1'b0;
      rtc_valid <= 1'b1;
    end else if (adv) begin
      pcnt      <= '0;
      rtc_out   <= rtc_next;
      sec_tick  <= 1'b1;
    end else begin
      pcnt      <= pcnt + PCNT_ONE;
      sec_tick  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rtc_bcd_clock.sv
// ============================================================================
// Module      : tb_rtc_bcd_clock
// Description : Directed self-checking bench for rtc_bcd_clock with CLK_HZ=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_bcd_clock;

  localparam int          CLK_HZ    = 4;
  localparam logic [63:0] RTC_RESET = 64'h00_01_00_01_01_00_00_00;

  logic        clk;
  logic        reset;
  logic [63:0] rtc_in;
  logic        rtc_load;
  logic [63:0] rtc_out;
  logic        sec_tick;
  logic        rtc_valid;

  int n_checks;
  int n_fail;

  rtc_bcd_clock #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .rtc_in   (rtc_in),
    .rtc_load (rtc_load),
    .rtc_out  (rtc_out),
    .sec_tick (sec_tick),
    .rtc_valid(rtc_valid)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if something wedges
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge where the load is visible
  task automatic do_load(input logic [63:0] v);
    rtc_in   = v;
    rtc_load = 1'b1;
    @(negedge clk);
    rtc_load = 1'b0;
  endtask

  // Bounded wait for the next sec_tick; n = negedges waited (16 means timeout)
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sec_tick && n < 16);
  endtask

  // Load a value, wait one tick, compare latency and result
  task automatic load_and_tick(input string name, input logic [63:0] v,
                               input logic [63:0] exp);
    int n;
    do_load(v);
    wait_tick(n);
    n_checks++;
    if (n !== CLK_HZ) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, n, CLK_HZ);
    end
    n_checks++;
    if (rtc_out !== exp) begin
      n_fail++;
      $display("FAIL %s value: got %h, want %h", name, rtc_out, exp);
    end
  endtask

  task automatic test_reset;
    int n;
    reset    = 1'b1;
    rtc_load = 1'b0;
    rtc_in   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (rtc_out !== RTC_RESET) begin
      n_fail++;
      $display("FAIL reset_value: got %h, want %h", rtc_out, RTC_RESET);
    end
    n_checks++;
    if (rtc_valid !== 1'b0 || sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b tick=%b, want 0 0", rtc_valid, sec_tick);
    end
    wait_tick(n);
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL first_tick_latency: got %0d, want 4", n);
    end
    n_checks++;
    if (rtc_out !== 64'h00_01_00_01_01_00_00_01) begin
      n_fail++;
      $display("FAIL first_tick_value: got %h, want %h", rtc_out, 64'h00_01_00_01_01_00_00_01);
    end
    @(negedge clk);
    n_checks++;
    if (sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_width: got tick=%b one cycle later, want 0", sec_tick);
    end
    wait_tick(n);
    n_checks++;
    if (n !== 3 || rtc_out[7:0] !== 8'h02) begin
      n_fail++;
      $display("FAIL second_tick: got %0d+1 cycles sec=%h, want 4 cycles sec=02", n, rtc_out[7:0]);
    end
  endtask

  task automatic test_rollover;
    load_and_tick("full_rollover", 64'hA5_07_99_12_31_23_59_59, 64'hA5_01_00_01_01_00_00_00);
    n_checks++;
    if (rtc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_after_load: got %b, want 1", rtc_valid);
    end
    load_and_tick("bcd_units_carry", 64'h00_03_05_06_19_19_59_59, 64'h00_03_05_06_19_20_00_00);
    load_and_tick("sec_only", 64'h00_03_05_06_19_20_00_09, 64'h00_03_05_06_19_20_00_10);
  endtask

  task automatic test_february;
    load_and_tick("leap24_28", 64'h00_03_24_02_28_23_59_59, 64'h00_04_24_02_29_00_00_00);
    load_and_tick("leap24_29", 64'h00_04_24_02_29_23_59_59, 64'h00_05_24_03_01_00_00_00);
    load_and_tick("leap12_28", 64'h00_02_12_02_28_23_59_59, 64'h00_03_12_02_29_00_00_00);
    load_and_tick("nonleap23", 64'h00_02_23_02_28_23_59_59, 64'h00_03_23_03_01_00_00_00);
  endtask

  task automatic test_month_length;
    load_and_tick("apr30", 64'h00_02_24_04_30_23_59_59, 64'h00_03_24_05_01_00_00_00);
    load_and_tick("may30", 64'h00_05_24_05_30_23_59_59, 64'h00_06_24_05_31_00_00_00);
    load_and_tick("sep30", 64'h00_01_24_09_30_23_59_59, 64'h00_02_24_10_01_00_00_00);
    load_and_tick("noon_no_dow", 64'h00_06_24_05_31_12_59_59, 64'h00_06_24_05_31_13_00_00);
    load_and_tick("pre_midnight", 64'h00_06_24_05_31_23_59_58, 64'h00_06_24_05_31_23_59_59);
  endtask

  task automatic test_collision;
    int n;
    do_load(64'h00_01_00_01_01_00_00_05);
    repeat (3) @(negedge clk);
    do_load(64'h00_01_00_01_01_00_00_10);
    n_checks++;
    if (sec_tick !== 1'b0 || rtc_out[7:0] !== 8'h10) begin
      n_fail++;
      $display("FAIL collision_load_wins: got tick=%b sec=%h, want tick=0 sec=10", sec_tick, rtc_out[7:0]);
    end
    wait_tick(n);
    n_checks++;
    if (n !== 4 || rtc_out[7:0] !== 8'h11) begin
      n_fail++;
      $display("FAIL collision_next_tick: got %0d cycles sec=%h, want 4 cycles sec=11", n, rtc_out[7:0]);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    rtc_in   = 64'h00_02_11_11_11_11_11_11;
    rtc_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rtc_in   = 64'h00_04_33_03_15_08_30_40;
    @(negedge clk);
    rtc_load = 1'b0;
    n_checks++;
    if (rtc_out !== 64'h00_04_33_03_15_08_30_40) begin
      n_fail++;
      $display("FAIL back_to_back_value: got %h, want %h", rtc_out, 64'h00_04_33_03_15_08_30_40);
    end
    wait_tick(n);
    n_checks++;
    if (n !== 4 || rtc_out !== 64'h00_04_33_03_15_08_30_41) begin
      n_fail++;
      $display("FAIL back_to_back_tick: got %0d cycles %h, want 4 cycles %h", n, rtc_out, 64'h00_04_33_03_15_08_30_41);
    end
  endtask

  task automatic test_reset_mid_count;
    int n;
    do_load(64'h00_03_20_07_04_10_20_30);
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    rtc_in   = 64'h00_05_55_05_05_05_05_05;
    rtc_load = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    rtc_load = 1'b0;
    n_checks++;
    if (rtc_out !== RTC_RESET || rtc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_load: got %h valid=%b, want %h valid=0", rtc_out, rtc_valid, RTC_RESET);
    end
    wait_tick(n);
    n_checks++;
    if (n !== 4 || rtc_out !== 64'h00_01_00_01_01_00_00_01) begin
      n_fail++;
      $display("FAIL reset_mid_tick: got %0d cycles %h, want 4 cycles %h", n, rtc_out, 64'h00_01_00_01_01_00_00_01);
    end
    load_and_tick("invalid_sec", 64'h00_01_00_01_01_00_12_75, 64'h00_01_00_01_01_00_13_00);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    rtc_load = 1'b0;
    rtc_in   = '0;
    @(negedge clk);
    test_reset();
    test_rollover();
    test_february();
    test_month_length();
    test_collision();
    test_back_to_back();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rtc_bcd_clock.md
# rtc_bcd_clock

Free-running BCD calendar clock that produces the 64-bit `rtc` time vector consumed by the PRAM/RTC serial block. It is loaded from the host-supplied time, advances one second every `CLK_HZ` clock cycles, and carries through minutes, hours, date, month, year and day-of-week with correct month lengths and leap years. It sits directly upstream of the PRAM/RTC block, so the seconds counter reported to the Mac keeps running between host updates.

## Interface
Parameters:
- `CLK_HZ`, default 32000000: clk cycles per second; legal range is 2 or more.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `rtc_in` in 64: host time, BCD. Layout:
  - [7:0] sec, [15:8] min, [23:16] hour
  - [31:24] date, [39:32] month, [47:40] year (00 = 2000)
  - [55:48] day-of-week (01–07), [63:56] spare
- `rtc_load` in 1: one-cycle strobe that captures `rtc_in`.
- `rtc_out` out 64: running time, same layout as `rtc_in`; registered.
- `sec_tick` out 1: one-cycle pulse in the cycle `rtc_out` shows an advanced second.
- `rtc_valid` out 1: high once any load has occurred since reset.

## Operation
- Prescaler `pcnt`, width `$clog2(CLK_HZ)`, counts 0..`CLK_HZ`-1 and wraps. Terminal count (`pcnt == CLK_HZ-1`) is the internal `adv`.
- On `adv`, update `rtc_out` in one step using a combinational carry chain:
  - **sec:** ≥ 0x59 → 00, carry; else BCD+1. BCD+1 means units 9 → 0 with tens+1, otherwise units+1.
  - **min:** same rule as sec, only when sec carried.
  - **hour:** ≥ 0x23 → 00, carry; else BCD+1.
  - **date:** ≥ `mlen` → 01, carry; else BCD+1.
  - **month:** ≥ 0x12 → 01, carry year; else BCD+1.
  - **year:** ≥ 0x99 → 00; else BCD+1.
  - **day-of-week:** advances on the date carry (midnight). ≥ 0x07 → 01; else +1.
  - **spare byte:** never modified by ticks.
- `mlen` (BCD):
  - months 01, 03, 05, 07, 08, 10, 12 → 0x31
  - months 04, 06, 09, 11 → 0x30
  - month 02 → 0x29 if leap, else 0x28
  - any other month value → 0x31
- Leap year means binary year mod 4 == 0: tens even with units in {0, 4, 8}, or tens odd with units in {2, 6}.
- Out-of-range loaded fields are not rejected. The ≥ comparisons make them roll over on their next increment, for example sec = 0x75 → 00 with carry.
- `rtc_load`: `rtc_out` ← `rtc_in`, `pcnt` ← 0, `rtc_valid` ← 1, `sec_tick` ← 0. If load and `adv` occur in the same cycle, the load wins and that tick is discarded.
- `reset` dominates `rtc_load`.

## Timing
- Reset values:
  - `rtc_out` = 64'h0001_0001_0100_0000 (Sat/dow 01, 2000-01-01 00:00:00)
  - `pcnt` = 0, `sec_tick` = 0, `rtc_valid` = 0
- After reset or a load, the first advance is visible exactly `CLK_HZ` cycles later. `pcnt` reaches `CLK_HZ`-1 on cycle `CLK_HZ`-1, and `rtc_out` and `sec_tick` update on the following edge.
- Successive `sec_tick` pulses are exactly `CLK_HZ` cycles apart and each is exactly 1 cycle wide.
- A loaded value appears on `rtc_out` on the edge following `rtc_load`.
- All fields change on the same edge: there is no ripple visible across cycles.
- No handshake: `rtc_load` may be asserted in any cycle, including back-to-back. The last load wins.

## Test plan
Run all scenarios with `CLK_HZ` = 4.
- **Reset and first tick:** release reset → `rtc_out` = reset value, `rtc_valid` = 0. On cycle 4, `sec_tick` = 1 and sec = 0x01; ticks follow every 4 cycles.
- **Full rollover:** load 99-12-31 23:59:59, dow 07, spare 0xA5. One tick later → 00-01-01 00:00:00, dow 01, spare still 0xA5.
- **Leap and non-leap February:**
  - load 24-02-28 23:59:59 → after 1 tick 24-02-29, after 86401 total ticks 24-03-01
  - load 23-02-28 23:59:59 → after 1 tick 23-03-01
- **Month length:** load 30-Apr 23:59:59 → 05-01; load 30-May 23:59:59 → 05-31; dow increments once per midnight only.
- **Load/tick collision:** assert `rtc_load` with sec 0x10 in the `adv` cycle → no `sec_tick`, sec = 0x10, and the next tick arrives 4 cycles later with sec = 0x11.
- **Reset mid-count plus invalid load:** reset after 2 cycles → `pcnt` restarts and the next tick is 4 cycles after reset release. Load sec 0x75 → next tick gives sec 00 and min+1.
